// File: rtl/scoreboard_np_if.sv
// Issue/writeback/read-port bundle for scoreboard_np; master drives requests, slave is the scoreboard.
interface scoreboard_np_if #(
  parameter int ISSUE_W = 2,
  parameter int READ_P  = 4,
  parameter int TID_W   = 3
);
  localparam int LANE_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int TAG_W  = TID_W + LANE_W;

  logic                           invalidate_i;
  logic                           issue_ready_o;
  logic [ISSUE_W-1:0]             is_i;
  logic [ISSUE_W-1:0][4:0]        is_w_addr_i;
  logic [TID_W-1:0]               is_w_id_o;
  logic [READ_P-1:0][4:0]         is_r_addr_i;
  logic [READ_P-1:0][TAG_W-1:0]   is_r_id_o;
  logic [READ_P-1:0]              is_r_valid_o;
  logic [ISSUE_W-1:0]             wb_valid_i;
  logic [ISSUE_W-1:0][4:0]        wb_w_addr_i;
  logic [TID_W-1:0]               wb_w_id_i;
  logic [TID_W-1:0]               inflight_o;

  modport master (
    output invalidate_i, is_i, is_w_addr_i, is_r_addr_i,
           wb_valid_i, wb_w_addr_i, wb_w_id_i,
    input  issue_ready_o, is_w_id_o, is_r_id_o, is_r_valid_o, inflight_o
  );

  modport slave (
    input  invalidate_i, is_i, is_w_addr_i, is_r_addr_i,
           wb_valid_i, wb_w_addr_i, wb_w_id_i,
    output issue_ready_o, is_w_id_o, is_r_id_o, is_r_valid_o, inflight_o
  );
endinterface

// File: rtl/scoreboard_np.sv
// Register scoreboard tagging in-flight issue groups; SCOREBOARD_WB_BYPASS_EN adds same-cycle writeback bypass.
// Latency: board writes visible next cycle; read tags/valids combinational from the boards.
// Backpressure: issue_ready_o drops at the tag-aliasing limit and while draining after invalidate.
module scoreboard_np #(
  parameter int ISSUE_W = 2,
  parameter int READ_P  = 4,
  parameter int TID_W   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  scoreboard_np_if.slave  bus
);
  localparam int LANE_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int TAG_W  = TID_W + LANE_W;
  localparam logic [TID_W-1:0] TID_ONE  = TID_W'(1);
  localparam logic [TID_W-1:0] TID_MAX  = '1;
  localparam logic [TID_W-1:0] INFL_LIM = TID_MAX - TID_ONE;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [TID_W-1:0] tid_q, tid_d, tid_prev;
  logic [TID_W-1:0] inflight_q, inflight_d;
  logic [TID_W-1:0] wait_id_q, wait_id_d;
  logic             issue_ready;
  logic             accept;
  logic             wb_any;

  logic [TAG_W-1:0] iss_brd [32];
  logic [TID_W-1:0] cmt_brd [32];

  logic [READ_P-1:0][TAG_W-1:0] rd_tag;
  logic [READ_P-1:0]            rd_valid;

  // Reserving one tag short of the full range keeps a live group from aliasing a committed tid.
  assign issue_ready = (inflight_q != INFL_LIM) && (state_q == IDLE);
  assign accept      = (|bus.is_i) && issue_ready;
  assign wb_any      = |bus.wb_valid_i;
  assign tid_prev    = (tid_q == TID_ONE) ? TID_MAX : (tid_q - TID_ONE);

  always_comb begin
    tid_d = tid_q;
    if (accept) begin
      tid_d = (tid_q == TID_MAX) ? TID_ONE : (tid_q + TID_ONE);
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !wb_any) begin
      inflight_d = inflight_q + TID_ONE;
    end else if (!accept && wb_any && (inflight_q != '0)) begin
      inflight_d = inflight_q - TID_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_id_d = wait_id_q;
    case (state_q)
      IDLE: begin
        // Nothing in flight and nothing issuing now means there is nothing to drain.
        if (bus.invalidate_i && (accept || (inflight_q != '0))) begin
          state_d   = DRAIN;
          wait_id_d = accept ? tid_q : tid_prev;
        end
      end
      DRAIN: begin
        if ((wb_any && (bus.wb_w_id_i == wait_id_q)) || (inflight_q == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tid_q      <= TID_ONE;
      inflight_q <= '0;
      wait_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      tid_q      <= tid_d;
      inflight_q <= inflight_d;
      wait_id_q  <= wait_id_d;
    end
  end

  // Lanes are walked in ascending order so the highest lane's write lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        iss_brd[i] <= '0;
        cmt_brd[i] <= '0;
      end
    end else begin
      for (int l = 0; l < ISSUE_W; l++) begin
        if (accept && (bus.is_w_addr_i[l] != 5'd0)) begin
          iss_brd[bus.is_w_addr_i[l]] <= {tid_q, LANE_W'(l)};
        end
        if (bus.wb_valid_i[l] && (bus.wb_w_addr_i[l] != 5'd0)) begin
          cmt_brd[bus.wb_w_addr_i[l]] <= bus.wb_w_id_i;
        end
      end
    end
  end

  always_comb begin
    rd_tag   = '0;
    rd_valid = '0;
    for (int p = 0; p < READ_P; p++) begin
      rd_tag[p]   = iss_brd[bus.is_r_addr_i[p]];
      rd_valid[p] = (rd_tag[p][TAG_W-1 -: TID_W] == cmt_brd[bus.is_r_addr_i[p]]);
`ifdef SCOREBOARD_WB_BYPASS_EN
      for (int l = 0; l < ISSUE_W; l++) begin
        if (bus.wb_valid_i[l] && (bus.wb_w_addr_i[l] == bus.is_r_addr_i[p]) &&
            (bus.is_r_addr_i[p] != 5'd0) &&
            (bus.wb_w_id_i == rd_tag[p][TAG_W-1 -: TID_W])) begin
          rd_valid[p] = 1'b1;
        end
      end
`else
      // Commit visibility comes only from the registered board, one cycle after writeback.
`endif
    end
  end

  assign bus.issue_ready_o = issue_ready;
  assign bus.is_w_id_o     = tid_q;
  assign bus.inflight_o    = inflight_q;
  assign bus.is_r_id_o     = rd_tag;
  assign bus.is_r_valid_o  = rd_valid;
endmodule

// File: tb/tb_scoreboard_np.sv
// Directed bench for scoreboard_np: reset, tagging, aliasing limit, drain, same-address lanes, async reset.
module tb_scoreboard_np;
  localparam int ISSUE_W = 2;
  localparam int READ_P  = 4;
  localparam int TID_W   = 3;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  scoreboard_np_if #(.ISSUE_W(ISSUE_W), .READ_P(READ_P), .TID_W(TID_W)) sif ();

  scoreboard_np #(.ISSUE_W(ISSUE_W), .READ_P(READ_P), .TID_W(TID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    sif.invalidate_i = 1'b0;
    sif.is_i         = '0;
    sif.is_w_addr_i  = '0;
    sif.wb_valid_i   = '0;
    sif.wb_w_addr_i  = '0;
    sif.wb_w_id_i    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic do_issue(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
    sif.is_i           = v;
    sif.is_w_addr_i[0] = a0;
    sif.is_w_addr_i[1] = a1;
    cyc();
    sif.is_i        = '0;
    sif.is_w_addr_i = '0;
    #1;
  endtask

  task automatic do_wb(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [2:0] id);
    sif.wb_valid_i     = v;
    sif.wb_w_addr_i[0] = a0;
    sif.wb_w_addr_i[1] = a1;
    sif.wb_w_id_i      = id;
    cyc();
    sif.wb_valid_i  = '0;
    sif.wb_w_addr_i = '0;
    sif.wb_w_id_i   = '0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr_inputs();
    sif.is_r_addr_i = '0;

    // Post-reset state, reading r5
    do_reset();
    sif.is_r_addr_i[0] = 5'd5;
    #1;
    chk("rst_ready", sif.issue_ready_o, 1);
    chk("rst_wid", sif.is_w_id_o, 1);
    chk("rst_inflight", sif.inflight_o, 0);
    chk("rst_rvalid", sif.is_r_valid_o, 4'hf);
    chk("rst_rid", sif.is_r_id_o, 0);

    // Two-lane issue r3/r4 with tid 1, then writeback
    do_issue(2'b11, 5'd3, 5'd4);
    chk("iss_inflight", sif.inflight_o, 1);
    chk("iss_wid", sif.is_w_id_o, 2);
    sif.is_r_addr_i[0] = 5'd3;
    sif.is_r_addr_i[1] = 5'd4;
    #1;
    chk("iss_rid_r3", sif.is_r_id_o[0], 4'b0010);
    chk("iss_rid_r4", sif.is_r_id_o[1], 4'b0011);
    chk("iss_rvalid_pre", sif.is_r_valid_o[1:0], 2'b00);
    sif.wb_valid_i     = 2'b11;
    sif.wb_w_addr_i[0] = 5'd3;
    sif.wb_w_addr_i[1] = 5'd4;
    sif.wb_w_id_i      = 3'd1;
    #1;
    chk("wb_rvalid_same", sif.is_r_valid_o[1:0], BYP ? 2'b11 : 2'b00);
    cyc();
    clr_inputs();
    #1;
    chk("wb_rvalid_next", sif.is_r_valid_o[1:0], 2'b11);
    chk("wb_inflight", sif.inflight_o, 0);

    // Same-address lanes: r0 never written, r7 takes lane 1
    do_issue(2'b11, 5'd0, 5'd0);
    sif.is_r_addr_i[0] = 5'd0;
    #1;
    chk("r0_rid", sif.is_r_id_o[0], 0);
    chk("r0_rvalid", sif.is_r_valid_o[0], 1);
    do_issue(2'b11, 5'd7, 5'd7);
    sif.is_r_addr_i[1] = 5'd7;
    #1;
    chk("r7_rid", sif.is_r_id_o[1], {3'd3, 1'b1});
    chk("r7_rvalid", sif.is_r_valid_o[1], 0);
    chk("dual_inflight", sif.inflight_o, 2);

    // Aliasing limit and tid wrap
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_issue(2'b01, 5'(10 + i), 5'd0);
    end
    chk("lim_inflight", sif.inflight_o, 6);
    chk("lim_ready", sif.issue_ready_o, 0);
    chk("lim_wid", sif.is_w_id_o, 7);
    do_issue(2'b01, 5'd20, 5'd0);
    sif.is_r_addr_i[2] = 5'd20;
    #1;
    chk("blk_wid", sif.is_w_id_o, 7);
    chk("blk_inflight", sif.inflight_o, 6);
    chk("blk_board", sif.is_r_id_o[2], 0);
    do_wb(2'b01, 5'd10, 5'd0, 3'd1);
    chk("wb1_ready", sif.issue_ready_o, 1);
    chk("wb1_inflight", sif.inflight_o, 5);
    do_issue(2'b01, 5'd21, 5'd0);
    chk("wrap_wid", sif.is_w_id_o, 1);
    do_wb(2'b01, 5'd11, 5'd0, 3'd2);
    do_issue(2'b01, 5'd22, 5'd0);
    sif.is_r_addr_i[2] = 5'd21;
    sif.is_r_addr_i[3] = 5'd22;
    #1;
    chk("wrap_tag7", sif.is_r_id_o[2], {3'd7, 1'b0});
    chk("wrap_tag1", sif.is_r_id_o[3], {3'd1, 1'b0});
    chk("wrap_wid2", sif.is_w_id_o, 2);

    // Invalidate with same-cycle issue, drain to the captured tid
    do_reset();
    sif.invalidate_i = 1'b1;
    cyc();
    sif.invalidate_i = 1'b0;
    #1;
    chk("inv_empty_ready", sif.issue_ready_o, 1);
    do_issue(2'b01, 5'd1, 5'd0);
    do_wb(2'b01, 5'd1, 5'd0, 3'd1);
    do_issue(2'b01, 5'd2, 5'd0);
    sif.invalidate_i = 1'b1;
    do_issue(2'b01, 5'd3, 5'd0);
    sif.invalidate_i = 1'b0;
    #1;
    chk("drn_ready", sif.issue_ready_o, 0);
    chk("drn_inflight", sif.inflight_o, 2);
    do_issue(2'b01, 5'd9, 5'd0);
    chk("drn_wid", sif.is_w_id_o, 4);
    do_wb(2'b01, 5'd2, 5'd0, 3'd2);
    chk("drn_wb2_ready", sif.issue_ready_o, 0);
    chk("drn_wb2_inflight", sif.inflight_o, 1);
    do_wb(2'b01, 5'd3, 5'd0, 3'd3);
    chk("drn_wb3_ready", sif.issue_ready_o, 1);
    chk("drn_wb3_inflight", sif.inflight_o, 0);

    // Asynchronous reset while draining
    do_reset();
    do_issue(2'b01, 5'd1, 5'd0);
    do_issue(2'b01, 5'd2, 5'd0);
    do_issue(2'b01, 5'd3, 5'd0);
    sif.invalidate_i = 1'b1;
    cyc();
    sif.invalidate_i = 1'b0;
    #1;
    chk("ar_pre_ready", sif.issue_ready_o, 0);
    chk("ar_pre_inflight", sif.inflight_o, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_ready", sif.issue_ready_o, 1);
    chk("ar_inflight", sif.inflight_o, 0);
    chk("ar_wid", sif.is_w_id_o, 1);
    sif.is_r_addr_i[0] = 5'd2;
    #1;
    chk("ar_board", sif.is_r_id_o[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("ar_post_ready", sif.issue_ready_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scoreboard_np.md
SCOREBOARD_NP -- requirements
Module: scoreboard_np

Interface
REQ-001 Parameters, one per line (name, default, meaning):
 - ISSUE_W, 2, issue/writeback lanes; LANE_W = max(1, clog2(ISSUE_W)).
 - READ_P, 4, source-operand read ports.
 - TID_W, 3, group-tag width; TID 0 reserved for "ready".
REQ-002 Ports, one per line (name, direction, width, meaning):
 - clk, in, 1, sole clock.
 - rst_n, in, 1, reset, asynchronous, active-low.
 - invalidate_i, in, 1, pipeline flush request.
 - issue_ready_o, out, 1, issue permitted this cycle.
 - is_i, in, ISSUE_W, per-lane issue valid.
 - is_w_addr_i, in, ISSUE_W x 5, per-lane destination register.
 - is_w_id_o, out, TID_W, TID assigned to the group issuing this cycle.
 - is_r_addr_i, in, READ_P x 5, source register per read port.
 - is_r_id_o, out, READ_P x (TID_W+LANE_W), producing tag {tid,lane} per port.
 - is_r_valid_o, out, READ_P, operand committed (no forwarding needed).
 - wb_valid_i, in, ISSUE_W, per-lane writeback valid.
 - wb_w_addr_i, in, ISSUE_W x 5, per-lane writeback register.
 - wb_w_id_i, in, TID_W, TID of writing-back group.
 - inflight_o, out, TID_W, issued-not-written-back group count.

Function
REQ-003 Issue accepted when |is_i && issue_ready_o; is_i while issue_ready_o low SHALL be ignored (no TID advance, no board write, no count change).
REQ-004 Issue board (32 x (TID_W+LANE_W)): on accepted issue, lane l with is_w_addr_i[l]!=0 SHALL write {tid_q, l} at is_w_addr_i[l]; visible to reads next cycle; same-address lanes: highest lane wins.
REQ-005 Commit board (32 x TID_W): wb_valid_i[l] with wb_w_addr_i[l]!=0 SHALL write wb_w_id_i; same-address: highest lane wins.
REQ-006 is_r_id_o[p] = issue board entry at is_r_addr_i[p]; is_r_valid_o[p] = (issue tid field == commit entry) — register 0 always {0,0} and valid.
REQ-007 tid_q SHALL advance once per accepted issue, 1..2^TID_W-1, wrapping max->1, never 0; is_w_id_o = tid_q.
REQ-008 inflight counter: +1 per accepted issue cycle, -1 per cycle with |wb_valid_i, both same cycle -> unchanged; saturates at 0 (no underflow).
REQ-009 issue_ready_o SHALL be low when inflight == 2^TID_W-2 (tag-aliasing guard) or FSM != IDLE.
REQ-010 FSM states IDLE, DRAIN. IDLE->DRAIN on invalidate_i, capturing wait_id = last accepted TID (tid_q of this cycle if issue accepted same cycle, else tid_q-1 with wrap); invalidate_i with inflight==0 and no same-cycle issue SHALL stay IDLE.
REQ-011 DRAIN->IDLE when (|wb_valid_i && wb_w_id_i == wait_id) or inflight==0; invalidate_i in DRAIN SHALL be ignored; writebacks keep updating commit board in DRAIN.
REQ-012 Group ordering: writebacks arrive in issue order, one group per cycle; out-of-order writeback is undefined.

Reset
REQ-013 rst_n low SHALL asynchronously set: tid_q=1, inflight=0, FSM=IDLE, wait_id=0, board entries all 0.
REQ-014 Post-reset outputs: issue_ready_o=1, is_w_id_o=1, inflight_o=0, all is_r_valid_o=1, all is_r_id_o=0.
REQ-015 Reset mid-DRAIN SHALL return to IDLE; no pending state survives.

Configuration
REQ-016 Macro SCOREBOARD_WB_BYPASS_EN: defined -> is_r_valid_o[p] also high same cycle when a writeback lane writes is_r_addr_i[p] (nonzero) with wb_w_id_i equal to its issue tid field; undefined -> valid only from registered commit board (one-cycle later).

Verification
REQ-017 Reset release, read r5 -> is_r_valid_o=1, is_r_id_o=0, is_w_id_o=1, issue_ready_o=1.
REQ-018 Issue lanes r3(l0), r4(l1) with tid 1, read r3/r4 next cycle -> ids {1,0}/{1,1}, valid=0; wb tid 1 -> valid=1 following cycle (same cycle with SCOREBOARD_WB_BYPASS_EN).
REQ-019 TID_W=3, 6 accepted issues without writeback -> inflight_o=6, issue_ready_o=0; 7th is_i ignored; one wb -> ready returns; subsequent TIDs 7 then 1 (wrap skips 0).
REQ-020 Issue tids 2,3, invalidate_i in same cycle as tid 3 issue -> ready low; wb tid 2 keeps DRAIN; wb tid 3 -> IDLE, ready=1 next cycle.
REQ-021 Both lanes write r0 and r7 same address both lanes -> r0 stays valid/id 0; r7 id lane field = 1.
REQ-022 Assert rst_n low during DRAIN with inflight=3 -> immediately ready=1, inflight_o=0, tid 1.
